hc4e_mem_io: RTL and testbench

- Data-side memory/IO unit directly downstream of the HC4e core's data bus.
- Services the core's 4-bit address / 4-bit data accesses:
  - 14 nibbles of RAM at 0x0–0xD.
  - Parallel output/input port at 0xE.
  - 4-bit serial transmitter at 0xF.
- Top-level glue converts the core's bus and instruction qualifiers into the level-valid enables below and drives the shared inout bus from data_out/data_oe.

---
 rtl/hc4e_mem_io.sv | 132 +++++++++++++
 tb/tb_hc4e_mem_io.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/hc4e_mem_io.sv
// HC4e data-side memory/IO unit: 14-nibble RAM, GPIO port at 0xE and a
// 4-bit serial transmitter at 0xF, all on a 4-bit address / 4-bit data bus.
module hc4e_mem_io #(
  parameter int BAUD_DIV    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] addr,
  input  logic [3:0] data_in,
  input  logic       mem_we,
  input  logic       mem_re,
  output logic [3:0] data_out,
  output logic       data_oe,
  output logic [3:0] gpio_out,
  input  logic [3:0] gpio_in,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_overrun
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [7:0] BAUD_LAST = 8'(BAUD_DIV - 1);
  localparam logic [2:0] BIT_LAST  = 3'd5;

  state_t     state, state_n;
  logic [7:0] baud_cnt, baud_n;
  logic [2:0] bit_idx, bit_n;
  logic [3:0] shreg, shreg_n;
  logic       overrun_n;
  logic       wr_tx;

  logic [3:0] ram [14];
  logic [3:0] sync_q [SYNC_STAGES];

  assign wr_tx = mem_we && (addr == 4'hF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 14; i++) ram[i] <= 4'h0;
      gpio_out <= 4'h0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'h0;
    end else begin
      if (mem_we && (addr < 4'hE)) ram[addr] <= data_in;
      if (mem_we && (addr == 4'hE)) gpio_out <= data_in;
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Transmitter control state; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      baud_cnt   <= 8'd0;
      bit_idx    <= 3'd0;
      tx_overrun <= 1'b0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_n;
      bit_idx    <= bit_n;
      tx_overrun <= overrun_n;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_n;
  end

  always_comb begin
    state_n   = state;
    baud_n    = baud_cnt;
    bit_n     = bit_idx;
    shreg_n   = shreg;
    overrun_n = 1'b0;
    case (state)
      IDLE: begin
        if (wr_tx) begin
          state_n = SHIFT;
          baud_n  = 8'd0;
          bit_n   = 3'd0;
          shreg_n = data_in;
        end
      end
      SHIFT: begin
        // A write while busy is dropped and flagged; the frame continues.
        if (wr_tx) overrun_n = 1'b1;
        if (baud_cnt == BAUD_LAST) begin
          baud_n = 8'd0;
          if (bit_idx == BIT_LAST) begin
            state_n = IDLE;
            bit_n   = 3'd0;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          baud_n = baud_cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Line is driven from registered state so reset forces it high at once.
  always_comb begin
    tx = 1'b1;
    if (state == SHIFT) begin
      case (bit_idx)
        3'd0:    tx = 1'b0;
        3'd1:    tx = shreg[0];
        3'd2:    tx = shreg[1];
        3'd3:    tx = shreg[2];
        3'd4:    tx = shreg[3];
        default: tx = 1'b1;
      endcase
    end
  end

  assign tx_busy = (state == SHIFT);
  assign data_oe = mem_re;

  always_comb begin
    data_out = 4'h0;
    if (mem_re) begin
      if (addr < 4'hE)       data_out = ram[addr];
      else if (addr == 4'hE) data_out = sync_q[SYNC_STAGES-1];
      else                   data_out = {3'b000, tx_busy};
    end
  end

endmodule

// File: tb/tb_hc4e_mem_io.sv
// Bench for hc4e_mem_io: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_hc4e_mem_io;

  localparam int BD = 4;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] addr = 4'h0;
  logic [3:0] data_in = 4'h0;
  logic       mem_we = 1'b0;
  logic       mem_re = 1'b0;
  logic [3:0] gpio_in = 4'h0;
  logic [3:0] data_out;
  logic       data_oe;
  logic [3:0] gpio_out;
  logic       tx;
  logic       tx_busy;
  logic       tx_overrun;

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  hc4e_mem_io #(.BAUD_DIV(BD), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in),
    .mem_we(mem_we), .mem_re(mem_re), .data_out(data_out), .data_oe(data_oe),
    .gpio_out(gpio_out), .gpio_in(gpio_in), .tx(tx), .tx_busy(tx_busy),
    .tx_overrun(tx_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: RAM array, GPIO sample history, and a queue holding the
  // expected line level for every remaining cycle of the current frame.
  logic [3:0] m_ram [14];
  logic [3:0] m_gpio;
  logic [3:0] m_hist [$];
  logic       m_txq [$];
  logic       m_ovr;
  logic       m_busy;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 14; i++) m_ram[i] = 4'h0;
      m_gpio = 4'h0;
      m_hist.delete();
      for (int i = 0; i < SS; i++) m_hist.push_back(4'h0);
      m_txq.delete();
      m_ovr = 1'b0;
    end else begin
      m_busy = (m_txq.size() != 0);
      if (m_busy) void'(m_txq.pop_front());
      m_ovr = 1'b0;
      if (mem_we) begin
        if (addr < 4'hE) m_ram[addr] = data_in;
        else if (addr == 4'hE) m_gpio = data_in;
        else if (m_busy) m_ovr = 1'b1;
        else begin
          for (int b = 0; b < 6; b++)
            for (int k = 0; k < BD; k++)
              m_txq.push_back(b == 0 ? 1'b0 : (b == 5 ? 1'b1 : data_in[b-1]));
        end
      end
      m_hist.push_back(gpio_in);
      void'(m_hist.pop_front());
    end
  end

  always @(negedge clk) begin
    logic [3:0] exp_rd;
    if (cmp_en && !reset) begin
      exp_rd = 4'h0;
      if (mem_re) begin
        if (addr < 4'hE) exp_rd = m_ram[addr];
        else if (addr == 4'hE) exp_rd = m_hist[0];
        else exp_rd = {3'b000, m_txq.size() != 0};
      end
      chk("m_data_out", 32'(data_out), 32'(exp_rd));
      chk("m_data_oe", 32'(data_oe), 32'(mem_re));
      chk("m_gpio_out", 32'(gpio_out), 32'(m_gpio));
      chk("m_tx", 32'(tx), 32'(m_txq.size() != 0 ? m_txq[0] : 1'b1));
      chk("m_tx_busy", 32'(tx_busy), 32'(m_txq.size() != 0));
      chk("m_tx_overrun", 32'(tx_overrun), 32'(m_ovr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] d);
    mem_we = 1'b1; addr = a; data_in = d;
    step();
    mem_we = 1'b0;
  endtask

  task automatic rdchk(input string nm, input logic [3:0] a, input logic [3:0] exp);
    mem_re = 1'b1; addr = a;
    #1;
    chk(nm, 32'(data_out), 32'(exp));
    chk({nm, "_oe"}, 32'(data_oe), 32'd1);
    step();
    mem_re = 1'b0;
  endtask

  // Entered in the first start-bit cycle; walks the frame until busy drops.
  task automatic run_frame(input logic [5:0] bits, input bit ovr);
    int n = 0;
    do begin
      mem_we = 1'b0; mem_re = 1'b0;
      if (ovr && n == 2) begin mem_we = 1'b1; addr = 4'hF; data_in = 4'h7; end
      if (n == 9) begin mem_re = 1'b1; addr = 4'hF; end
      #1;
      if (n % BD == 0) chk($sformatf("tx_bit%0d", n / BD), 32'(tx), 32'(bits[n / BD]));
      if (n == 9) chk("rd_busy_mid", 32'(data_out), 32'd1);
      if (ovr && n == 3) chk("overrun_pulse", 32'(tx_overrun), 32'd1);
      if (ovr && n == 4) chk("overrun_clear", 32'(tx_overrun), 32'd0);
      step();
      n++;
    end while (tx_busy && n < 200);
    mem_we = 1'b0; mem_re = 1'b0;
    chk("busy_len", 32'(n), 32'(6 * BD));
    chk("tx_idle", 32'(tx), 32'd1);
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cmp_en = 1'b1;

    // 1: reset clears pre-written RAM
    wr(4'h2, 4'h7);
    wr(4'hD, 4'h4);
    rdchk("rd_prewrite", 4'h2, 4'h7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 14; i++) rdchk($sformatf("rd_reset_%0d", i), 4'(i), 4'h0);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_gpio", 32'(gpio_out), 32'd0);
    chk("rst_busy", 32'(tx_busy), 32'd0);

    // 2: RAM write/read, read disabled, simultaneous write+read
    wr(4'h3, 4'h5);
    wr(4'hD, 4'hC);
    rdchk("rd_3", 4'h3, 4'h5);
    rdchk("rd_d", 4'hD, 4'hC);
    mem_re = 1'b0; addr = 4'h3;
    #1;
    chk("rd_off_data", 32'(data_out), 32'd0);
    chk("rd_off_oe", 32'(data_oe), 32'd0);
    step();
    mem_we = 1'b1; mem_re = 1'b1; addr = 4'h3; data_in = 4'hB;
    #1;
    chk("rw_old", 32'(data_out), 32'h5);
    step();
    mem_we = 1'b0;
    #1;
    chk("rw_new", 32'(data_out), 32'hB);
    mem_re = 1'b0;
    step();

    // 3: GPIO out latch and input synchronizer latency
    wr(4'hE, 4'h9);
    chk("gpio_out", 32'(gpio_out), 32'h9);
    gpio_in = 4'h6; mem_re = 1'b1; addr = 4'hE;
    #1;
    chk("gpio_in_lat0", 32'(data_out), 32'h0);
    for (int i = 1; i <= SS; i++) begin
      step();
      chk($sformatf("gpio_in_lat%0d", i), 32'(data_out), (i == SS) ? 32'h6 : 32'h0);
    end
    mem_re = 1'b0;
    step();

    // 4: frame for 0xA, then idle status read
    wr(4'hF, 4'hA);
    run_frame(6'b110100, 1'b0);
    rdchk("rd_busy_done", 4'hF, 4'h0);

    // 5: overrun mid-frame, then back-to-back frame with no gap
    wr(4'hF, 4'h3);
    run_frame(6'b100110, 1'b1);
    wr(4'hF, 4'h5);
    chk("b2b_busy", 32'(tx_busy), 32'd1);
    chk("b2b_start", 32'(tx), 32'd0);
    run_frame(6'b101010, 1'b0);

    // 6: reset mid-frame aborts immediately
    wr(4'hF, 4'h0);
    repeat (10) step();
    reset = 1'b1;
    #1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(tx_busy), 32'd0);
    chk("abort_ovr", 32'(tx_overrun), 32'd0);
    step();
    reset = 1'b0;
    step();
    wr(4'hF, 4'hF);
    run_frame(6'b111110, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
